rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s0_valid in 1 / s0_ready out 1 / s0_addr in ADDR_WIDTH / s0_data in DATA_WIDTH  writeback source 0 (ALU).
REQ-006 SHALL have ports s1_valid in 1 / s1_ready out 1 / s1_addr in ADDR_WIDTH / s1_data in DATA_WIDTH  writeback source 1 (LSU).
REQ-007 SHALL have ports wen out 1 / waddr out ADDR_WIDTH / wdata out DATA_WIDTH  single register-file write port, registered.
REQ-008 SHALL have ports rsv_valid in 1 / rsv_addr in ADDR_WIDTH  destination reservation at issue.
REQ-009 SHALL have ports chk_addr1 in ADDR_WIDTH / chk_addr2 in ADDR_WIDTH / hazard out 1  source-operand busy check.

Function
REQ-010 SHALL transfer source n when sn_valid and sn_ready are both high at a rising edge.
REQ-011 SHALL assert at most one of s0_ready/s1_ready per cycle; sn_ready is combinational from valids and the priority pointer, never dependent on sn_ready itself.
REQ-012 SHALL grant the only valid source when one is valid; neither ready when none is valid.
REQ-013 SHALL, when both are valid, grant the source named by the 1-bit priority pointer prio.
REQ-014 SHALL, on every transfer, set prio to the source not granted.
REQ-015 SHALL register a transfer into wen=1, waddr, wdata on the same edge; outputs appear one cycle after acceptance.
REQ-016 SHALL drive wen=0 the cycle after any edge with no transfer; waddr/wdata then hold their last values.
REQ-017 SHALL accept a transfer with address 0 normally (ready, prio update) but drive wen=0 for it.
REQ-018 SHALL keep a busy bit per register (2**ADDR_WIDTH bits); bit 0 is constantly 0.
REQ-019 SHALL set busy[rsv_addr] on an edge with rsv_valid=1 and rsv_addr!=0.
REQ-020 SHALL clear busy[waddr] on an edge where output wen=1, so hazard drops only once the register file holds the data.
REQ-021 SHALL, when set and clear target the same index on one edge, leave the bit set.
REQ-022 SHALL drive hazard = busy[chk_addr1] | busy[chk_addr2], combinational, no same-cycle bypass.
REQ-023 SHALL sustain one write per cycle under continuous back-to-back traffic.

Reset
REQ-024 SHALL, while rst=1, force wen=0, waddr=0, wdata=0, prio=0 and all busy bits to 0, independent of clk.
REQ-025 SHALL discard any transfer in flight when rst asserts mid-operation; no write issues after rst deasserts.
REQ-026 SHALL drive s0_ready/s1_ready from valids and prio=0 during reset; transfers on edges with rst=1 are ignored.

Configuration
REQ-027 SHALL, with macro RF_WB_ARBITER_RR_EN defined, use round-robin arbitration per REQ-013/REQ-014.
REQ-028 SHALL, without RF_WB_ARBITER_RR_EN, use fixed priority: source 0 always wins when both are valid. prio is not implemented; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover: s0 only, addr 3, data 0xDEADBEEF -> s0_ready=1; next cycle wen=1, waddr=3, wdata=0xDEADBEEF; the following cycle wen=0.
REQ-030 SHALL cover (RR build): both valid 4 cycles after reset, s0 addr 1, s1 addr 2 -> grants s0,s1,s0,s1; waddr sequence 1,2,1,2 one cycle delayed.
REQ-031 SHALL cover (non-RR build): same stimulus as REQ-030 -> grants s0 every cycle; s1_ready stays 0.
REQ-032 SHALL cover: rsv addr 5; chk_addr1=5 -> hazard=1; s1 writes 5 -> hazard stays 1 through the wen=1 cycle and is 0 the next cycle.
REQ-033 SHALL cover: s0 writes addr 0, data 0x1 -> s0_ready=1, wen stays 0; rsv_addr=0 with chk_addr2=0 -> hazard=0.
REQ-034 SHALL cover: rsv addr 7 and wen=1 with waddr=7 on one edge -> busy[7] stays 1; rst pulse mid-stream -> wen=0 and hazard=0 immediately.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source register-file writeback arbiter with busy scoreboard
//
// Purpose:
//   Merges two writeback sources (s0 = ALU, s1 = LSU) onto one registered
//   register-file write port. It also keeps one busy bit per register so that
//   issue logic can stall on operands whose results are still pending.
//
// Configuration:
//   RF_WB_ARBITER_RR_EN  defined   -> round-robin between s0/s1 via 1-bit pointer
//                        undefined -> fixed priority, s0 wins when both are valid
//
// Ports:
//   clk                  in   sole clock, rising edge
//   rst                  in   asynchronous active-high reset
//   s0_valid/s0_ready    in/out  source 0 handshake
//   s0_addr/s0_data      in   source 0 destination index and result
//   s1_valid/s1_ready    in/out  source 1 handshake
//   s1_addr/s1_data      in   source 1 destination index and result
//   wen/waddr/wdata      out  registered register-file write port
//   rsv_valid/rsv_addr   in   destination reservation at issue (sets busy)
//   chk_addr1/chk_addr2  in   source operand indices to check
//   hazard               out  either checked operand is busy

module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  hazard
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NREG-1:0]       w_set;
  logic [NREG-1:0]       w_clr;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREG-1:0]       r_busy;

`ifdef RF_WB_ARBITER_RR_EN
  // r_prio names the source that wins a tie; it flips to the loser on every
  // transfer so neither source can starve the other.
  logic r_prio;

  assign w_grant0 = s0_valid & (~s1_valid | ~r_prio);
  assign w_grant1 = s1_valid & (~s0_valid |  r_prio);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_xfer) begin
      r_prio <= w_grant0;
    end
  end
`else
  assign w_grant0 = s0_valid;
  assign w_grant1 = s1_valid & ~s0_valid;
`endif

  // Ready depends only on valids (and the pointer), so a grant is a transfer.
  assign s0_ready   = w_grant0;
  assign s1_ready   = w_grant1;
  assign w_xfer     = w_grant0 | w_grant1;
  assign w_sel_addr = w_grant1 ? s1_addr : s0_addr;
  assign w_sel_data = w_grant1 ? s1_data : s0_data;

  // Writes to register 0 are accepted but suppressed at the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  // Clearing keys off the registered write port, so hazard stays up until the
  // register file actually holds the value. Set is applied after clear, so a
  // same-edge collision leaves the bit set.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_valid) begin
      w_set[rsv_addr] = 1'b1;
    end
    if (r_wen) begin
      w_clr[r_waddr] = 1'b1;
    end
    w_set[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~{{(NREG-1){1'b0}}, 1'b1};
    end
  end

  assign wen    = r_wen;
  assign waddr  = r_waddr;
  assign wdata  = r_wdata;
  assign hazard = r_busy[chk_addr1] | r_busy[chk_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr, waddr, rsv_addr, chk_addr1, chk_addr2;
  logic [31:0] s0_data, s1_data, wdata;
  logic        wen, rsv_valid, hazard;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s1_valid = 0; rsv_valid = 0;
    s0_addr = 0; s1_addr = 0; s0_data = 0; s1_data = 0;
    rsv_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    s0_valid = 1; s1_valid = 1;
    #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", wen); end
    n_checks++; if (waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    n_checks++; if ({s0_ready, s1_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_ready_both got=%b exp=10", {s0_ready, s1_ready}); end
    s0_valid = 0;
    #1;
    n_checks++; if ({s0_ready, s1_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_ready_s1 got=%b exp=01", {s0_ready, s1_ready}); end
    tick();
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL reset_edge_ignored wen got=%b exp=0", wen); end
    idle_inputs();
    #1;
    n_checks++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got=%b exp=00", {s0_ready, s1_ready}); end
    rst = 0;
    #1;
  endtask

  task automatic test_single_write();
    do_reset();
    s0_valid = 1; s0_addr = 5'd3; s0_data = 32'hDEADBEEF;
    #1;
    n_checks++; if ({s0_ready, s1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready got=%b exp=10", {s0_ready, s1_ready}); end
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL single_pre_wen got=%b exp=0", wen); end
    tick();
    s0_valid = 0;
    n_checks++; if (wen !== 1'b1) begin n_fail++; $display("FAIL single_wen got=%b exp=1", wen); end
    n_checks++; if (waddr !== 5'd3) begin n_fail++; $display("FAIL single_waddr got=%0d exp=3", waddr); end
    n_checks++; if (wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata got=%h exp=deadbeef", wdata); end
    tick();
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop got=%b exp=0", wen); end
    n_checks++; if (waddr !== 5'd3 || wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold got=%0d/%h exp=3/deadbeef", waddr, wdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g1;
    logic [4:0] exp_a;
`ifdef RF_WB_ARBITER_RR_EN
    exp_g1 = 4'b1010;
`else
    exp_g1 = 4'b0000;
`endif
    do_reset();
    s0_valid = 1; s0_addr = 5'd1; s0_data = 32'hA0;
    s1_valid = 1; s1_addr = 5'd2; s1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({s0_ready, s1_ready} !== {~exp_g1[i], exp_g1[i]}) begin
        n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, {s0_ready, s1_ready}, {~exp_g1[i], exp_g1[i]});
      end
      tick();
      exp_a = exp_g1[i] ? 5'd2 : 5'd1;
      n_checks++;
      if (wen !== 1'b1 || waddr !== exp_a || wdata !== (exp_g1[i] ? 32'hB1 : 32'hA0)) begin
        n_fail++; $display("FAIL b2b_write[%0d] got=%b/%0d/%h exp=1/%0d", i, wen, waddr, wdata, exp_a);
      end
    end
    idle_inputs();
    tick();
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL b2b_end_wen got=%b exp=0", wen); end
  endtask

  task automatic test_hazard();
    do_reset();
    rsv_valid = 1; rsv_addr = 5'd5;
    tick();
    rsv_valid = 0; chk_addr1 = 5'd5; chk_addr2 = 5'd0;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_set got=%b exp=1", hazard); end
    chk_addr1 = 5'd0; chk_addr2 = 5'd5;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_chk2 got=%b exp=1", hazard); end
    chk_addr1 = 5'd5; chk_addr2 = 5'd0;
    s1_valid = 1; s1_addr = 5'd5; s1_data = 32'h55;
    #1;
    n_checks++; if ({s0_ready, s1_ready} !== 2'b01) begin n_fail++; $display("FAIL hazard_s1_ready got=%b exp=01", {s0_ready, s1_ready}); end
    tick();
    s1_valid = 0;
    n_checks++; if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h55) begin n_fail++; $display("FAIL hazard_write got=%b/%0d/%h exp=1/5/55", wen, waddr, wdata); end
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_during_wen got=%b exp=1", hazard); end
    tick();
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_cleared got=%b exp=0", hazard); end
  endtask

  task automatic test_addr_zero();
    do_reset();
    s0_valid = 1; s0_addr = 5'd0; s0_data = 32'h1;
    #1;
    n_checks++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%b exp=1", s0_ready); end
    tick();
    s0_valid = 0;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL zero_wen got=%b exp=0", wen); end
    rsv_valid = 1; rsv_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    tick();
    rsv_valid = 0;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL zero_hazard got=%b exp=0", hazard); end
  endtask

  task automatic test_collision_and_reset();
    do_reset();
    rsv_valid = 1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 0;
    s0_valid = 1; s0_addr = 5'd7; s0_data = 32'h77;
    tick();
    s0_valid = 0;
    n_checks++; if (wen !== 1'b1 || waddr !== 5'd7) begin n_fail++; $display("FAIL coll_write got=%b/%0d exp=1/7", wen, waddr); end
    rsv_valid = 1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 0; chk_addr1 = 5'd7;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL coll_busy_kept got=%b exp=1", hazard); end
    s0_valid = 1; s0_addr = 5'd4; s0_data = 32'h44;
    tick();
    n_checks++; if (wen !== 1'b1 || waddr !== 5'd4) begin n_fail++; $display("FAIL midrst_pre got=%b/%0d exp=1/4", wen, waddr); end
    #2;
    rst = 1;
    #1;
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL midrst_wen got=%b exp=0", wen); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL midrst_hazard got=%b exp=0", hazard); end
    n_checks++; if (waddr !== 5'd0 || wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_port got=%0d/%h exp=0/0", waddr, wdata); end
    tick();
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL midrst_edge_wen got=%b exp=0", wen); end
    idle_inputs();
    #2;
    rst = 0;
    tick();
    n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL postrst_wen got=%b exp=0", wen); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hazard();
    test_addr_zero();
    test_collision_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
